io_seq_ctrl: RTL and testbench
==============================

// Module: io_seq_ctrl
// PURPOSE
//  Control-unit sequencer for ULM I/O instructions (putc imm, putc reg, getc reg).
//  Accepts one decoded I/O op from the decoder, reads the source register if needed,
//  and hands the byte to the UART TX or takes a byte from the UART RX.
//  For getc it writes the received byte back to the register file.
//  Stalls the core via busy until the op retires; sits between decoder, reg file and UART.
// PARAMETERS
//  BYTE_W     pkg_ram::RAM_BYTE_SIZE (8)  width of a character
//  REG_ADDRW  pkg_reg::REG_ADDRW          register address width
//  REG_DATAW  64                          register data width
//  CNT_W      16                          width of retired-char counters
// PORTS
//  clk          in   1          system clock, rising edge
//  rst_n        in   1          asynchronous reset, active low
//  start        in   1          decoder: execute op this cycle (sampled only in IDLE)
//  op           in   op_t       pkg_io::op_t: IO_NOP / IO_PUTC_IMM / IO_PUTC_REG / IO_GETC
//  char_imm     in   BYTE_W     immediate char for IO_PUTC_IMM
//  char_reg     in   REG_ADDRW  source (putc) or destination (getc) register
//  reg_rd_addr  out  REG_ADDRW  reg file read address
//  reg_rd_data  in   REG_DATAW  reg file read data, valid 1 cycle after address
//  reg_we       out  1          reg file write enable (single-cycle pulse)
//  reg_wr_addr  out  REG_ADDRW  reg file write address
//  reg_wr_data  out  REG_DATAW  reg file write data
//  tx_data      out  BYTE_W     UART TX byte
//  tx_valid     out  1          UART TX request
//  tx_ready     in   1          UART TX accepts when tx_valid&&tx_ready
//  rx_data      in   BYTE_W     UART RX byte
//  rx_valid     in   1          UART RX byte available
//  rx_ready     out  1          consume RX byte when rx_valid&&rx_ready
//  busy         out  1          op in flight; core must hold PC
//  done         out  1          1-cycle pulse when op retires
//  tx_count     out  CNT_W      bytes transmitted since reset
//  rx_count     out  CNT_W      bytes received since reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0 (counters 0, addresses/data 0).
//  States: IDLE, RD_REG, RD_WAIT, TX, RX, WB, DONE.
//  IDLE: busy=0. start&&op==IO_PUTC_IMM -> latch char_imm into tx_data, go TX.
//    start&&op==IO_PUTC_REG -> reg_rd_addr<=char_reg, go RD_REG.
//    start&&op==IO_GETC -> latch char_reg as dest, go RX. start&&IO_NOP -> go DONE.
//    Any other op value -> treated as IO_NOP.
//  RD_REG: wait 1 cycle for registered read; go RD_WAIT.
//  RD_WAIT: tx_data<=reg_rd_data[BYTE_W-1:0] (upper bits ignored); go TX.
//  TX: tx_valid=1, tx_data stable; on tx_valid&&tx_ready: tx_count++, go DONE.
//  RX: rx_ready=1; on rx_valid&&rx_ready: latch rx_data, rx_count++, go WB.
//  WB: reg_we=1 one cycle, reg_wr_addr=dest, reg_wr_data={zeros,byte}; go DONE.
//  DONE: done=1 one cycle; go IDLE. busy=1 in every state except IDLE.
//  Latency (start to done): PUTC_IMM 2 cycles min, PUTC_REG 4 min, GETC 3 min, NOP 1.
//  Unbounded wait in TX/RX while peer not ready; no timeout.
//  start/op/char_* ignored while busy; inputs sampled only in IDLE on start.
//  tx_valid never deasserts before handshake; rx_ready only asserted in RX.
//  Counters wrap modulo 2^CNT_W, no saturation.
//  Write to register 0 is still issued; reg file enforces r0 hardwiring.
//  Reset mid-op aborts immediately: no TX/RX handshake or reg write completes afterwards.
// TESTING
//  putc imm 'A'(0x41), tx_ready=1 -> tx_valid 1 cycle with 0x41, done 2 cycles after start.
//  putc reg r3=0x1234_5678_9ABC_DE48 -> reg_rd_addr=3, tx_data=0x48, tx_count=1.
//  getc r5, rx_valid after 10 cycles with 0x7A -> reg_we pulse, addr 5, data 0x7A, rx_count=1.
//  tx_ready held 0 for 20 cycles -> tx_valid/tx_data stable, busy=1, start ignored.
//  rst_n low during TX wait -> all outputs 0, IDLE, no tx handshake after release.
//  2^CNT_W+1 putc ops -> tx_count wraps to 1; back-to-back start right after done accepted.

Source files
------------

// File: rtl/pkg_io.sv
// Shared I/O sequencer types: character/register widths and the decoded I/O opcode.
package pkg_io;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned REG_ADDRW = 5;

  typedef enum logic [1:0] {
    IO_NOP      = 2'd0,
    IO_PUTC_IMM = 2'd1,
    IO_PUTC_REG = 2'd2,
    IO_GETC     = 2'd3
  } op_t;

endpackage

// File: rtl/io_seq_ctrl.sv
// Sequencer for ULM putc/getc: fetches the source register, drives the UART
// handshakes, writes received bytes back and stalls the core until retirement.
module io_seq_ctrl #(
  parameter int unsigned BYTE_W    = pkg_io::BYTE_W,
  parameter int unsigned REG_ADDRW = pkg_io::REG_ADDRW,
  parameter int unsigned REG_DATAW = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  pkg_io::op_t          op,
  input  logic [BYTE_W-1:0]    char_imm,
  input  logic [REG_ADDRW-1:0] char_reg,
  output logic [REG_ADDRW-1:0] reg_rd_addr,
  input  logic [REG_DATAW-1:0] reg_rd_data,
  output logic                 reg_we,
  output logic [REG_ADDRW-1:0] reg_wr_addr,
  output logic [REG_DATAW-1:0] reg_wr_data,
  output logic [BYTE_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [BYTE_W-1:0]    rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     tx_count,
  output logic [CNT_W-1:0]     rx_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REG  = 3'd1,
    RD_WAIT = 3'd2,
    TX      = 3'd3,
    RX      = 3'd4,
    WB      = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [REG_ADDRW-1:0] dest_q, dest_d;
  logic [REG_ADDRW-1:0] reg_rd_addr_d;
  logic                 reg_we_d;
  logic [REG_ADDRW-1:0] reg_wr_addr_d;
  logic [REG_DATAW-1:0] reg_wr_data_d;
  logic [BYTE_W-1:0]    tx_data_d;
  logic                 tx_valid_d;
  logic                 rx_ready_d;
  logic                 busy_d;
  logic                 done_d;
  logic [CNT_W-1:0]     tx_count_d;
  logic [CNT_W-1:0]     rx_count_d;

  // Only the low byte of a source register is transmitted.
  logic unused_rd_upper;
  assign unused_rd_upper = ^reg_rd_data[REG_DATAW-1:BYTE_W];

  // State and all outputs are registered; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      reg_rd_addr <= '0;
      reg_we      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      rx_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_count    <= '0;
      rx_count    <= '0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      reg_rd_addr <= reg_rd_addr_d;
      reg_we      <= reg_we_d;
      reg_wr_addr <= reg_wr_addr_d;
      reg_wr_data <= reg_wr_data_d;
      tx_data     <= tx_data_d;
      tx_valid    <= tx_valid_d;
      rx_ready    <= rx_ready_d;
      busy        <= busy_d;
      done        <= done_d;
      tx_count    <= tx_count_d;
      rx_count    <= rx_count_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    dest_d        = dest_q;
    reg_rd_addr_d = reg_rd_addr;
    reg_we_d      = 1'b0;
    reg_wr_addr_d = reg_wr_addr;
    reg_wr_data_d = reg_wr_data;
    tx_data_d     = tx_data;
    tx_count_d    = tx_count;
    rx_count_d    = rx_count;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            pkg_io::IO_PUTC_IMM: begin
              tx_data_d = char_imm;
              state_d   = TX;
            end
            pkg_io::IO_PUTC_REG: begin
              reg_rd_addr_d = char_reg;
              state_d       = RD_REG;
            end
            pkg_io::IO_GETC: begin
              dest_d  = char_reg;
              state_d = RX;
            end
            default: state_d = DONE;
          endcase
        end
      end
      RD_REG:  state_d = RD_WAIT;
      RD_WAIT: begin
        tx_data_d = reg_rd_data[BYTE_W-1:0];
        state_d   = TX;
      end
      TX: begin
        if (tx_valid && tx_ready) begin
          tx_count_d = tx_count + CNT_W'(1);
          state_d    = DONE;
        end
      end
      RX: begin
        // Write-back is staged here so WB presents it as a single registered pulse.
        if (rx_valid && rx_ready) begin
          reg_we_d      = 1'b1;
          reg_wr_addr_d = dest_q;
          reg_wr_data_d = REG_DATAW'(rx_data);
          rx_count_d    = rx_count + CNT_W'(1);
          state_d       = WB;
        end
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tx_valid_d = (state_d == TX);
    rx_ready_d = (state_d == RX);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

endmodule

// File: tb/tb_io_seq_ctrl.sv
// Randomized self-checking bench for io_seq_ctrl against a transaction-level model.
module tb_io_seq_ctrl;
  import pkg_io::*;

  localparam int unsigned BW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  op_t           op;
  logic [BW-1:0] char_imm;
  logic [AW-1:0] char_reg;
  logic [AW-1:0] reg_rd_addr;
  logic [DW-1:0] reg_rd_data;
  logic          reg_we;
  logic [AW-1:0] reg_wr_addr;
  logic [DW-1:0] reg_wr_data;
  logic [BW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [BW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_seq_ctrl #(.BYTE_W(BW), .REG_ADDRW(AW), .REG_DATAW(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .char_imm(char_imm),
    .char_reg(char_reg), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .reg_we(reg_we), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .tx_count(tx_count), .rx_count(rx_count)
  );

  // Register file peer: registered read, r0 hardwired to zero, preload port for the bench.
  logic [DW-1:0] regs [32];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_val = '0;

  always @(posedge clk) begin
    reg_rd_data <= (reg_rd_addr == '0) ? '0 : regs[reg_rd_addr];
    if (pl_en) regs[pl_addr] <= pl_val;
    else if (reg_we) regs[reg_wr_addr] <= reg_wr_data;
  end

  // Observed transactions.
  logic [BW-1:0]    tx_q [$];
  logic [AW+DW-1:0] wr_q [$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (reg_we) wr_q.push_back({reg_wr_addr, reg_wr_data});
    end
  end

  // Reference model state.
  logic [DW-1:0] mregs [32];
  int exp_tx;
  int exp_rx;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Start-to-done cycles given the peer becomes ready d cycles after start.
  function automatic int exp_lat(input op_t o, input int d);
    case (o)
      IO_PUTC_IMM: return max2(2, d + 1);
      IO_PUTC_REG: return max2(4, d + 1);
      IO_GETC:     return max2(2, d + 1) + 1;
      default:     return 1;
    endcase
  endfunction

  function automatic int exp_txv(input op_t o, input int lat);
    case (o)
      IO_PUTC_IMM: return lat - 1;
      IO_PUTC_REG: return lat - 3;
      default:     return 0;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; op = IO_NOP; char_imm = '0; char_reg = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_tx = 0;
    exp_rx = 0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
    mregs[a] = (a == '0) ? '0 : v;
  endtask

  // Issue one op; garbage is driven on start/op/char_* while busy. Returns observations only.
  task automatic run_op(input op_t o, input logic [BW-1:0] imm, input logic [AW-1:0] r,
                        input int d, input logic [BW-1:0] rxb,
                        output int lat, output bit busy_ok, output int txv);
    lat = -1; busy_ok = 1'b1; txv = 0;
    @(negedge clk);
    start = 1'b1; op = o; char_imm = imm; char_reg = r; rx_data = rxb;
    tx_ready = (d == 0); rx_valid = (d == 0);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      op = op_t'($urandom_range(0, 3));
      char_imm = BW'($urandom);
      char_reg = AW'($urandom);
      if (tx_valid) txv++;
      if (!busy) busy_ok = 1'b0;
      tx_ready = (k >= d);
      rx_valid = (k >= d);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    if (busy || done) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [BW+3*AW+DW+2*CW+5-1:0] snap;
    do_reset();
    snap = {tx_valid, rx_ready, reg_we, busy, done, tx_data, reg_rd_addr,
            reg_wr_addr, char_reg ^ char_reg, reg_wr_data, tx_count, rx_count};
    total++;
    if (snap !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %0h want 0", snap);
    end
  endtask

  task automatic test_putc_imm();
    int lat; bit bok; int txv; int n0;
    n0 = tx_q.size();
    run_op(IO_PUTC_IMM, 8'h41, '0, 0, 8'h00, lat, bok, txv);
    exp_tx++;
    total++;
    if (lat !== 2) begin bad++; $display("FAIL putc_imm_latency: got %0d want 2", lat); end
    total++;
    if (txv !== 1) begin bad++; $display("FAIL putc_imm_txvalid_cycles: got %0d want 1", txv); end
    total++;
    if (tx_q.size() !== n0 + 1 || tx_q[tx_q.size()-1] !== 8'h41) begin
      bad++; $display("FAIL putc_imm_byte: got n=%0d want n=%0d byte 41", tx_q.size() - n0, 1);
    end
    total++;
    if (tx_count !== CW'(exp_tx % (1 << CW))) begin
      bad++; $display("FAIL putc_imm_count: got %0d want %0d", tx_count, exp_tx % (1 << CW));
    end
  endtask

  task automatic test_putc_reg();
    int lat; bit bok; int txv; int n0;
    preload(5'd3, 64'h1234_5678_9ABC_DE48);
    n0 = tx_q.size();
    run_op(IO_PUTC_REG, 8'hFF, 5'd3, 0, 8'h00, lat, bok, txv);
    exp_tx++;
    total++;
    if (reg_rd_addr !== 5'd3) begin bad++; $display("FAIL putc_reg_addr: got %0d want 3", reg_rd_addr); end
    total++;
    if (tx_q.size() !== n0 + 1 || tx_q[tx_q.size()-1] !== 8'h48) begin
      bad++; $display("FAIL putc_reg_byte: got %0h want 48", (tx_q.size() > 0) ? tx_q[tx_q.size()-1] : 8'h00);
    end
    total++;
    if (lat !== 4 || !bok) begin bad++; $display("FAIL putc_reg_latency: got %0d busy_ok=%0d want 4", lat, bok); end
    total++;
    if (tx_count !== CW'(exp_tx % (1 << CW))) begin
      bad++; $display("FAIL putc_reg_count: got %0d want %0d", tx_count, exp_tx % (1 << CW));
    end
  endtask

  task automatic test_getc();
    int lat; bit bok; int txv; int w0;
    w0 = wr_q.size();
    run_op(IO_GETC, 8'h00, 5'd5, 10, 8'h7A, lat, bok, txv);
    exp_rx++;
    mregs[5] = 64'h7A;
    total++;
    if (wr_q.size() !== w0 + 1 || wr_q[wr_q.size()-1] !== {5'd5, 64'h7A}) begin
      bad++; $display("FAIL getc_write: got n=%0d want one write r5=7a", wr_q.size() - w0);
    end
    total++;
    if (rx_count !== CW'(exp_rx % (1 << CW))) begin
      bad++; $display("FAIL getc_count: got %0d want %0d", rx_count, exp_rx % (1 << CW));
    end
    total++;
    if (lat !== exp_lat(IO_GETC, 10) || !bok) begin
      bad++; $display("FAIL getc_latency: got %0d want %0d busy_ok=%0d", lat, exp_lat(IO_GETC, 10), bok);
    end
    total++;
    if (regs[5] !== mregs[5]) begin bad++; $display("FAIL getc_regfile: got %0h want %0h", regs[5], mregs[5]); end
  endtask

  task automatic test_tx_stall();
    bit stall_ok; bit got_done; int n0; int w0; int rxc0;
    n0 = tx_q.size(); w0 = wr_q.size(); rxc0 = rx_count;
    stall_ok = 1'b1; got_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = IO_PUTC_IMM; char_imm = 8'hC3; tx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== 8'hC3 || !busy) stall_ok = 1'b0;
      start = 1'b1; op = IO_GETC; char_imm = BW'($urandom); char_reg = 5'd9;
    end
    start = 1'b0; rx_valid = 1'b1; rx_data = 8'h11; tx_ready = 1'b1;
    for (int k = 0; k < 10 && !got_done; k++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    tx_ready = 1'b0;
    exp_tx++;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if (!stall_ok) begin bad++; $display("FAIL stall_stable: got unstable tx_valid/tx_data/busy want stable C3"); end
    total++;
    if (!got_done || tx_q.size() !== n0 + 1 || tx_q[tx_q.size()-1] !== 8'hC3) begin
      bad++; $display("FAIL stall_release: got done=%0d n=%0d want done=1 n=1", got_done, tx_q.size() - n0);
    end
    total++;
    if (wr_q.size() !== w0 || int'(rx_count) !== rxc0 || busy !== 1'b0) begin
      bad++; $display("FAIL stall_start_ignored: got writes=%0d rx_count=%0d busy=%0d want 0 %0d 0",
                      wr_q.size() - w0, rx_count, busy, rxc0);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [BW+AW+DW+2*CW+5-1:0] snap; int n0;
    @(negedge clk);
    start = 1'b1; op = IO_PUTC_IMM; char_imm = 8'h55; tx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n0 = tx_q.size();
    #2 rst_n = 1'b0;
    #1;
    snap = {tx_valid, rx_ready, reg_we, busy, done, tx_data, reg_rd_addr,
            reg_wr_data, tx_count, rx_count};
    total++;
    if (snap !== '0) begin bad++; $display("FAIL reset_mid_op_outputs: got %0h want 0", snap); end
    exp_tx = 0; exp_rx = 0;
    @(negedge clk);
    rst_n = 1'b1; tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    tx_ready = 1'b0;
    total++;
    if (tx_q.size() !== n0 || tx_count !== '0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_op_abort: got hs=%0d tx_count=%0d busy=%0d want 0 0 0",
                      tx_q.size() - n0, tx_count, busy);
    end
  endtask

  task automatic test_random();
    int lat; bit bok; int txv; int n0; int w0; int errs;
    op_t o; logic [BW-1:0] imm; logic [AW-1:0] r; int d; logic [BW-1:0] rxb;
    for (int i = 0; i < 32; i++) preload(AW'(i), {$urandom, $urandom});
    for (int i = 0; i < 40; i++) begin
      o = op_t'($urandom_range(0, 3)); imm = BW'($urandom); r = AW'($urandom);
      d = $urandom_range(0, 6); rxb = BW'($urandom);
      n0 = tx_q.size(); w0 = wr_q.size(); errs = 0;
      run_op(o, imm, r, d, rxb, lat, bok, txv);
      if (lat !== exp_lat(o, d) || !bok || txv !== exp_txv(o, lat)) errs++;
      case (o)
        IO_PUTC_IMM, IO_PUTC_REG: begin
          exp_tx++;
          if (tx_q.size() !== n0 + 1 || wr_q.size() !== w0) errs++;
          else if (tx_q[n0] !== ((o == IO_PUTC_IMM) ? imm : mregs[r][BW-1:0])) errs++;
        end
        IO_GETC: begin
          exp_rx++;
          if (r != '0) mregs[r] = DW'(rxb);
          if (wr_q.size() !== w0 + 1 || tx_q.size() !== n0) errs++;
          else if (wr_q[w0] !== {r, DW'(rxb)}) errs++;
        end
        default: if (tx_q.size() !== n0 || wr_q.size() !== w0) errs++;
      endcase
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL random_op%0d: op=%0d d=%0d got lat=%0d txv=%0d busy_ok=%0d want lat=%0d",
                 i, o, d, lat, txv, bok, exp_lat(o, d));
      end
    end
    total++;
    if (tx_count !== CW'(exp_tx % (1 << CW)) || rx_count !== CW'(exp_rx % (1 << CW))) begin
      bad++; $display("FAIL random_counts: got %0d/%0d want %0d/%0d", tx_count, rx_count,
                      exp_tx % (1 << CW), exp_rx % (1 << CW));
    end
  endtask

  task automatic test_back_to_back_wrap();
    int lat; bit bok; int txv; int n0; int errs;
    do_reset();
    n0 = tx_q.size(); errs = 0;
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      run_op(IO_PUTC_IMM, BW'(8'h30 + i), '0, 0, 8'h00, lat, bok, txv);
      exp_tx++;
      if (lat !== 2 || !bok) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL b2b_latency: got %0d bad ops want 0", errs); end
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      if (n0 + i >= tx_q.size() || tx_q[n0 + i] !== BW'(8'h30 + i)) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL b2b_bytes: got %0d wrong want 0", errs); end
    total++;
    if (tx_count !== CW'(exp_tx % (1 << CW)) || tx_count !== CW'(1)) begin
      bad++; $display("FAIL count_wrap: got %0d want %0d", tx_count, exp_tx % (1 << CW));
    end
  endtask

  task automatic test_nop();
    int lat; bit bok; int txv; int n0; int w0;
    n0 = tx_q.size(); w0 = wr_q.size();
    run_op(IO_NOP, 8'h99, 5'd7, 0, 8'h00, lat, bok, txv);
    total++;
    if (lat !== 1 || !bok || tx_q.size() !== n0 || wr_q.size() !== w0) begin
      bad++; $display("FAIL nop: got lat=%0d busy_ok=%0d want lat=1 no traffic", lat, bok);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    test_reset();
    for (int i = 0; i < 32; i++) preload(AW'(i), '0);
    test_putc_imm();
    test_putc_reg();
    test_getc();
    test_nop();
    test_tx_stall();
    test_reset_mid_op();
    test_random();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
